// File: rtl/iir_mac_scheduler.sv
// First-order recursive filter controller y[n] = a*y[n-1] + b*x[n], sharing a
// single 2-stage pipelined multiplier between the b*x and a*y products.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a sample; coefficient writes accepted
// MB     | issue b * x_reg to the multiplier
// MA     | issue a * y (y still holds y[n-1])
// CB     | b*x product arrives, captured into acc
// CA     | a*y product arrives, y <= acc + product
// DONE   | y_valid strobe, new y presented
module iir_mac_scheduler #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [DATA_W-1:0] x,
    input  logic              coef_we,
    input  logic              coef_sel,
    input  logic [ACC_W-1:0]  coef_data,
    output logic              y_valid,
    output logic [ACC_W-1:0]  y,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MB   = 3'd1,
        S_MA   = 3'd2,
        S_CB   = 3'd3,
        S_CA   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] x_reg_q, x_reg_d;
    logic [ACC_W-1:0] a_q, a_d;
    logic [ACC_W-1:0] b_q, b_d;
    logic [ACC_W-1:0] op0_q, op0_d;
    logic [ACC_W-1:0] op1_q, op1_d;
    logic [ACC_W-1:0] prod_q, prod_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] y_q, y_d;
    logic             accept;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_reg_q <= '0;
            a_q     <= ACC_W'(2);
            b_q     <= ACC_W'(3);
            op0_q   <= '0;
            op1_q   <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_reg_q <= x_reg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_reg_d = x_reg_q;
        a_d     = a_q;
        b_d     = b_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        acc_d   = acc_q;
        y_d     = y_q;
        prod_d  = op0_q * op1_q;
        accept  = x_valid && (state_q == S_IDLE);

        // An IDLE-cycle write lands before MB reads b, so it applies to a sample accepted alongside it.
        if (coef_we && (state_q == S_IDLE)) begin
            if (coef_sel) b_d = coef_data;
            else          a_d = coef_data;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    x_reg_d = {{(ACC_W-DATA_W){1'b0}}, x};
                    state_d = S_MB;
                end
            end
            S_MB: begin
                op0_d   = b_q;
                op1_d   = x_reg_q;
                state_d = S_MA;
            end
            S_MA: begin
                op0_d   = a_q;
                op1_d   = y_q;
                state_d = S_CB;
            end
            S_CB: begin
                acc_d   = prod_q;
                state_d = S_CA;
            end
            S_CA: begin
                y_d     = acc_q + prod_q;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign x_ready = (state_q == S_IDLE);
    assign y_valid = (state_q == S_DONE);
    assign busy    = (state_q != S_IDLE);
    assign y       = y_q;

endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Bench for iir_mac_scheduler: directed scenarios plus randomized samples and
// coefficient writes, checked against a plain-arithmetic recursion model.
module tb_iir_mac_scheduler;

    logic        clk;
    logic        reset;
    logic        x_valid;
    logic        x_ready;
    logic [7:0]  x;
    logic        coef_we;
    logic        coef_sel;
    logic [31:0] coef_data;
    logic        y_valid;
    logic [31:0] y;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_a, m_b, m_y;

    iir_mac_scheduler #(.DATA_W(8), .ACC_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x         (x),
        .coef_we   (coef_we),
        .coef_sel  (coef_sel),
        .coef_data (coef_data),
        .y_valid   (y_valid),
        .y         (y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset   = 1'b0;
        x_valid = 1'b0;
        coef_we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_a = 32'd2;
        m_b = 32'd3;
        m_y = 32'd0;
    endtask

    task automatic write_coef(input logic sel, input logic [31:0] data);
        coef_we   = 1'b1;
        coef_sel  = sel;
        coef_data = data;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        if (sel) m_b = data;
        else     m_a = data;
    endtask

    // Offers one sample (optionally with a coefficient write in the same cycle) and checks its result.
    task automatic process(input logic [7:0] xv, input logic we, input logic sel,
                           input logic [31:0] data, input string name,
                           output logic [31:0] y_obs);
        int          wait_c;
        int          lat;
        logic        rdy_seen;
        logic [31:0] exp_y;
        wait_c = 0;
        while (!x_ready && wait_c < 20) begin
            @(posedge clk);
            #1;
            wait_c++;
        end
        n_cmp++;
        if (x_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ready_wait x_ready=%0b required=1", name, x_ready);
        end
        if (we) begin
            if (sel) m_b = data;
            else     m_a = data;
        end
        exp_y = m_a * m_y + m_b * {24'd0, xv};
        x_valid   = 1'b1;
        x         = xv;
        coef_we   = we;
        coef_sel  = sel;
        coef_data = data;
        @(posedge clk);
        #1;
        x_valid  = 1'b0;
        coef_we  = 1'b0;
        lat      = 1;
        rdy_seen = 1'b0;
        while (!y_valid && lat < 12) begin
            if (x_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat !== 5 || y_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_latency cycles=%0d y_valid=%0b required=5", name, lat, y_valid);
        end
        n_cmp++;
        if (rdy_seen !== 1'b0 || x_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s_ready_low ready_seen=%0b required=0", name, rdy_seen);
        end
        n_cmp++;
        if (y !== exp_y) begin
            n_err++;
            $display("FAIL %s_y y=%0h required=%0h", name, y, exp_y);
        end
        y_obs = y;
        m_y   = exp_y;
        @(posedge clk);
        #1;
        n_cmp++;
        if (y_valid !== 1'b0 || x_ready !== 1'b1 || y !== exp_y) begin
            n_err++;
            $display("FAIL %s_after_pulse y_valid=%0b x_ready=%0b y=%0h required 0/1/%0h",
                     name, y_valid, x_ready, y, exp_y);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (x_ready !== 1'b1 || y_valid !== 1'b0 || busy !== 1'b0 || y !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state x_ready=%0b y_valid=%0b busy=%0b y=%0h required 1/0/0/0",
                     x_ready, y_valid, busy, y);
        end
    endtask

    task automatic test_recursion();
        logic [31:0] yo;
        logic [31:0] req [4] = '{32'd3, 32'd9, 32'd21, 32'd42};
        logic [7:0]  xs  [4] = '{8'd1, 8'd1, 8'd1, 8'd0};
        for (int i = 0; i < 4; i++) begin
            process(xs[i], 1'b0, 1'b0, 32'd0, "recursion", yo);
            n_cmp++;
            if (yo !== req[i]) begin
                n_err++;
                $display("FAIL recursion_const idx=%0d y=%0d required=%0d", i, yo, req[i]);
            end
        end
    endtask

    task automatic test_coef_idle();
        logic [31:0] yo;
        write_coef(1'b0, 32'd0);
        write_coef(1'b1, 32'd5);
        process(8'd4, 1'b0, 1'b0, 32'd0, "coef_idle", yo);
        n_cmp++;
        if (yo !== 32'd20) begin
            n_err++;
            $display("FAIL coef_idle_const y=%0d required=20", yo);
        end
        process(8'd1, 1'b1, 1'b0, 32'd1, "coef_same_cycle", yo);
        n_cmp++;
        if (yo !== 32'd25) begin
            n_err++;
            $display("FAIL coef_same_cycle_const y=%0d required=25", yo);
        end
    endtask

    task automatic test_write_busy();
        int          lat;
        logic [31:0] yo;
        x_valid = 1'b1;
        x       = 8'd1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        coef_we   = 1'b1;
        coef_sel  = 1'b1;
        coef_data = 32'd100;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        lat = 0;
        while (!y_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 32'd30) begin
            n_err++;
            $display("FAIL write_busy_y y_valid=%0b y=%0d required=30", y_valid, y);
        end
        m_y = m_a * m_y + m_b * 32'd1;
        @(posedge clk);
        #1;
        process(8'd1, 1'b0, 1'b0, 32'd0, "write_busy_b_kept", yo);
        n_cmp++;
        if (yo !== 32'd35) begin
            n_err++;
            $display("FAIL write_busy_b_kept_const y=%0d required=35", yo);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] yo;
        write_coef(1'b0, 32'd0);
        write_coef(1'b1, 32'h8000_0000);
        process(8'd2, 1'b0, 1'b0, 32'd0, "wrap_zero", yo);
        n_cmp++;
        if (yo !== 32'd0) begin
            n_err++;
            $display("FAIL wrap_zero_const y=%0h required=0", yo);
        end
        write_coef(1'b1, 32'hFFFF_FFFF);
        process(8'd1, 1'b0, 1'b0, 32'd0, "wrap_max", yo);
        n_cmp++;
        if (yo !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL wrap_max_const y=%0h required=ffffffff", yo);
        end
    endtask

    task automatic test_reset_mid();
        logic        vseen;
        logic [31:0] yo;
        x_valid = 1'b1;
        x       = 8'd7;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_a = 32'd2;
        m_b = 32'd3;
        m_y = 32'd0;
        vseen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (y_valid) vseen = 1'b1;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (vseen !== 1'b0 || y !== 32'd0 || busy !== 1'b0 || x_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_state y_valid_seen=%0b y=%0h busy=%0b x_ready=%0b required 0/0/0/1",
                     vseen, y, busy, x_ready);
        end
        process(8'd1, 1'b0, 1'b0, 32'd0, "reset_mid_b", yo);
        n_cmp++;
        if (yo !== 32'd3) begin
            n_err++;
            $display("FAIL reset_mid_b_const y=%0d required=3", yo);
        end
        process(8'd0, 1'b0, 1'b0, 32'd0, "reset_mid_a", yo);
        n_cmp++;
        if (yo !== 32'd6) begin
            n_err++;
            $display("FAIL reset_mid_a_const y=%0d required=6", yo);
        end
    endtask

    task automatic test_backpressure();
        int          acc_cyc[$];
        logic [31:0] outs[$];
        logic [31:0] exp_y;
        int          lat;
        do_reset();
        x_valid = 1'b1;
        x       = 8'd1;
        for (int c = 0; c < 20; c++) begin
            if (x_ready) acc_cyc.push_back(c);
            @(posedge clk);
            #1;
            if (y_valid) outs.push_back(y);
        end
        x_valid = 1'b0;
        lat = 0;
        while (!y_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (y_valid) outs.push_back(y);
        n_cmp++;
        if (acc_cyc.size() !== 4) begin
            n_err++;
            $display("FAIL backpressure_accepts count=%0d required=4", acc_cyc.size());
        end
        for (int i = 0; i < acc_cyc.size() && i < 4; i++) begin
            n_cmp++;
            if (acc_cyc[i] !== 6 * i) begin
                n_err++;
                $display("FAIL backpressure_accept_cycle idx=%0d cycle=%0d required=%0d",
                         i, acc_cyc[i], 6 * i);
            end
        end
        n_cmp++;
        if (outs.size() !== 4) begin
            n_err++;
            $display("FAIL backpressure_outputs count=%0d required=4", outs.size());
        end
        for (int i = 0; i < 4; i++) begin
            exp_y = m_a * m_y + m_b * 32'd1;
            m_y   = exp_y;
            if (i < outs.size()) begin
                n_cmp++;
                if (outs[i] !== exp_y) begin
                    n_err++;
                    $display("FAIL backpressure_y idx=%0d y=%0d required=%0d", i, outs[i], exp_y);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] yo;
        logic        we;
        logic        sel;
        logic [31:0] data;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0)
                write_coef(1'($urandom_range(0, 1)), $urandom);
            we   = ($urandom_range(0, 3) == 0);
            sel  = 1'($urandom_range(0, 1));
            data = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            process(8'($urandom_range(0, 255)), we, sel, data, "random", yo);
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        x_valid   = 1'b0;
        x         = 8'd0;
        coef_we   = 1'b0;
        coef_sel  = 1'b0;
        coef_data = 32'd0;
        m_a = 32'd2;
        m_b = 32'd3;
        m_y = 32'd0;
        test_reset();
        test_recursion();
        test_coef_idle();
        test_write_busy();
        test_wrap();
        test_reset_mid();
        test_backpressure();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
